// File: rtl/seq_pkg.sv
// Shared types and constants for the polynomial operand sequencer.
package seq_pkg;

    localparam int unsigned LARGURA_PADRAO = 16;
    localparam int unsigned IDX_W          = 2;

    // Operand slot selected by the running word index during CARGA
    localparam logic [IDX_W-1:0] IDX_X = 2'd0;
    localparam logic [IDX_W-1:0] IDX_A = 2'd1;
    localparam logic [IDX_W-1:0] IDX_B = 2'd2;
    localparam logic [IDX_W-1:0] IDX_C = 2'd3;

    typedef enum logic [1:0] {
        CARGA   = 2'd0,
        DISPARO = 2'd1,
        ESPERA  = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector for the core done flag; pronto_q is the previous-cycle sample.
module detector_borda (
    input  logic ck,
    input  logic rst,
    input  logic pronto_i,
    output logic borda_c_o
);

    logic pronto_q;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            pronto_q <= 1'b0;
        end else begin
            pronto_q <= pronto_i;
        end
    end

    // The core may hold pronto high across operations, so only a 0->1 transition counts
    assign borda_c_o = pronto_i & ~pronto_q;

endmodule

// File: rtl/sequenciador_polinomio.sv
// Operand sequencer in front of the polynomial core: loads X/A/B/C, starts the core, returns the result.
// Optional ESPERA watchdog enabled with `define SEQ_TIMEOUT_EN.
module sequenciador_polinomio
    import seq_pkg::*;
#(
    parameter int unsigned LARGURA    = LARGURA_PADRAO,
    parameter int unsigned MAX_ESPERA = 64
) (
    input  logic               ck,
    input  logic               rst,
    input  logic [LARGURA-1:0] dado_in,
    input  logic               dado_valido,
    output logic               dado_pronto,
    output logic [LARGURA-1:0] X,
    output logic [LARGURA-1:0] A,
    output logic [LARGURA-1:0] B,
    output logic [LARGURA-1:0] C,
    output logic               inicio,
    input  logic [LARGURA-1:0] Resultado,
    input  logic               pronto,
    input  logic               overflow,
    output logic [LARGURA-1:0] res_out,
    output logic               res_overflow,
    output logic               res_valido,
    input  logic               res_aceito,
    output logic               erro_timeout,
    output logic [7:0]         ops_concluidas
);

    localparam int unsigned OPS_W = 8;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned            CNT_W         = 8;
    localparam logic [CNT_W-1:0]       LIMITE_ESPERA = CNT_W'(MAX_ESPERA - 1);

    logic [CNT_W-1:0] espera_cnt_q, espera_cnt_d;
`else
    localparam int unsigned MAX_ESPERA_UNUSED = MAX_ESPERA;
`endif

    estado_t            estado_q, estado_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LARGURA-1:0] x_q, x_d;
    logic [LARGURA-1:0] a_q, a_d;
    logic [LARGURA-1:0] b_q, b_d;
    logic [LARGURA-1:0] c_q, c_d;
    logic               inicio_q, inicio_d;
    logic               dado_pronto_q, dado_pronto_d;
    logic [LARGURA-1:0] res_q, res_d;
    logic               res_ovf_q, res_ovf_d;
    logic               res_valido_q, res_valido_d;
    logic               erro_q, erro_d;
    logic [OPS_W-1:0]   ops_q, ops_d;
    logic               pronto_borda_c;
    logic               aceita_c;

    detector_borda u_borda (
        .ck        (ck),
        .rst       (rst),
        .pronto_i  (pronto),
        .borda_c_o (pronto_borda_c)
    );

    assign aceita_c = dado_valido & dado_pronto_q;

    // Next-state and registered-output logic
    always_comb begin
        estado_d     = estado_q;
        idx_d        = idx_q;
        x_d          = x_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        res_d        = res_q;
        res_ovf_d    = res_ovf_q;
        res_valido_d = res_valido_q;
        erro_d       = 1'b0;
        ops_d        = ops_q;
`ifdef SEQ_TIMEOUT_EN
        espera_cnt_d = espera_cnt_q;
`endif

        case (estado_q)
            CARGA: begin
                if (aceita_c) begin
                    case (idx_q)
                        IDX_X:   x_d = dado_in;
                        IDX_A:   a_d = dado_in;
                        IDX_B:   b_d = dado_in;
                        default: c_d = dado_in;
                    endcase
                    if (idx_q == IDX_C) begin
                        idx_d    = IDX_X;
                        estado_d = DISPARO;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            DISPARO: begin
                estado_d = ESPERA;
`ifdef SEQ_TIMEOUT_EN
                espera_cnt_d = '0;
`endif
            end

            ESPERA: begin
                // A pronto edge always beats the watchdog in the same cycle
                if (pronto_borda_c) begin
                    res_d        = Resultado;
                    res_ovf_d    = overflow;
                    res_valido_d = 1'b1;
                    estado_d     = ENTREGA;
`ifdef SEQ_TIMEOUT_EN
                end else if (espera_cnt_q == LIMITE_ESPERA) begin
                    erro_d   = 1'b1;
                    idx_d    = IDX_X;
                    estado_d = CARGA;
                end else begin
                    espera_cnt_d = espera_cnt_q + CNT_W'(1);
`endif
                end
            end

            ENTREGA: begin
                if (res_valido_q && res_aceito) begin
                    ops_d        = ops_q + OPS_W'(1);
                    res_valido_d = 1'b0;
                    idx_d        = IDX_X;
                    estado_d     = CARGA;
                end
            end

            default: begin
                idx_d    = IDX_X;
                estado_d = CARGA;
            end
        endcase

        dado_pronto_d = (estado_d == CARGA);
        inicio_d      = (estado_d == DISPARO);
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            estado_q      <= CARGA;
            idx_q         <= IDX_X;
            x_q           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            inicio_q      <= 1'b0;
            dado_pronto_q <= 1'b0;
            res_q         <= '0;
            res_ovf_q     <= 1'b0;
            res_valido_q  <= 1'b0;
            erro_q        <= 1'b0;
            ops_q         <= '0;
`ifdef SEQ_TIMEOUT_EN
            espera_cnt_q  <= '0;
`endif
        end else begin
            estado_q      <= estado_d;
            idx_q         <= idx_d;
            x_q           <= x_d;
            a_q           <= a_d;
            b_q           <= b_d;
            c_q           <= c_d;
            inicio_q      <= inicio_d;
            dado_pronto_q <= dado_pronto_d;
            res_q         <= res_d;
            res_ovf_q     <= res_ovf_d;
            res_valido_q  <= res_valido_d;
            erro_q        <= erro_d;
            ops_q         <= ops_d;
`ifdef SEQ_TIMEOUT_EN
            espera_cnt_q  <= espera_cnt_d;
`endif
        end
    end

    assign dado_pronto    = dado_pronto_q;
    assign X              = x_q;
    assign A              = a_q;
    assign B              = b_q;
    assign C              = c_q;
    assign inicio         = inicio_q;
    assign res_out        = res_q;
    assign res_overflow   = res_ovf_q;
    assign res_valido     = res_valido_q;
    assign erro_timeout   = erro_q;
    assign ops_concluidas = ops_q;

endmodule

// File: doc/sequenciador_polinomio.md
# sequenciador_polinomio

Operand sequencer placed directly upstream of the polynomial core (ports `X`, `A`, `B`, `C`, `inicio` in; `Resultado`, `pronto`, `overflow` out). It accepts four 16-bit words over a valid/ready stream in the fixed order X, A, B, C, then holds them stable on the core inputs. It pulses `inicio`, waits for the core to finish, and returns the captured result with its overflow flag over a second valid/ready handshake. An optional watchdog aborts the operation if the core never answers.

## Interface
- `LARGURA`, 16, width of every operand and of the result.
- `MAX_ESPERA`, 64, maximum cycles spent in ESPERA before timeout (used only with `SEQ_TIMEOUT_EN`); must be ≥ 2.
- `ck`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `dado_in`  in  LARGURA  operand word.
- `dado_valido`  in  1  `dado_in` is valid.
- `dado_pronto`  out  1  sequencer accepts a word this cycle.
- `X`, `A`, `B`, `C`  out  LARGURA each  operands to the core.
- `inicio`  out  1  start pulse to the core.
- `Resultado`  in  LARGURA  core result.
- `pronto`  in  1  core done flag (level).
- `overflow`  in  1  core overflow flag, valid when `pronto`=1.
- `res_out`  out  LARGURA  captured result.
- `res_overflow`  out  1  captured overflow flag.
- `res_valido`  out  1  `res_out` and `res_overflow` are valid.
- `res_aceito`  in  1  consumer takes the result.
- `erro_timeout`  out  1  one-cycle pulse when the watchdog fires.
- `ops_concluidas`  out  8  count of delivered results; wraps from 255 to 0.

## Operation
- States:
  - CARGA: `dado_pronto`=1; a word is taken on `dado_valido&dado_pronto`. Index 0..3 selects the destination register X, A, B, C. After index 3 the state goes to DISPARO.
  - DISPARO: `inicio`=1 for exactly this one cycle; go to ESPERA.
  - ESPERA: wait for a rising edge of `pronto` (`pronto & ~pronto_q`). On that edge, latch `Resultado` into `res_out` and `overflow` into `res_overflow`, then go to ENTREGA.
  - ENTREGA: hold `res_valido`=1. On `res_valido&res_aceito`, increment `ops_concluidas`, clear `res_valido`, return to CARGA with index 0.
- Rising-edge detection is required because the core may still hold `pronto` high from the previous operation.
- `X`, `A`, `B`, `C` change only on an accepted word in CARGA. They stay stable through DISPARO, ESPERA and ENTREGA.
- `dado_valido` outside CARGA is ignored (`dado_pronto`=0). `res_aceito` while `res_valido`=0 is ignored.
- `res_out` and `res_overflow` keep their last value after the handshake until the next capture.
- No arithmetic is done here; the result and overflow are passed through unchanged.

## Timing
- Reset values: state CARGA, index 0, `X`=`A`=`B`=`C`=0, `inicio`=0, `dado_pronto`=0 while `rst` is high and 1 on the first cycle after release. Also `res_out`=0, `res_overflow`=0, `res_valido`=0, `erro_timeout`=0, `ops_concluidas`=0, `pronto_q`=0.
- Reset asserted mid-operation aborts immediately: the partial load is discarded and no result is delivered.
- Acceptance of the 4th word to `inicio` high: 1 cycle. `inicio` is never high for 2 consecutive cycles.
- Rising edge of `pronto` to `res_valido`=1: 1 cycle.
- Handshake cycle to `dado_pronto`=1: 1 cycle.
- Minimum cycles per operation with no stalls: 4 load + 1 DISPARO + core latency + 1 capture + 1 delivery.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to ESPERA and increments every ESPERA cycle.
  - When it reaches `MAX_ESPERA`-1 with no `pronto` edge: `erro_timeout`=1 for one cycle, state returns to CARGA with index 0, and `res_valido` stays 0.
  - A `pronto` edge in the same cycle as the timeout wins: the result is captured and no error is raised.
- `SEQ_TIMEOUT_EN` undefined: ESPERA waits indefinitely, `erro_timeout` is tied to 0, and `MAX_ESPERA` is unused.

## Structure
- Package `seq_pkg`:
  - State enum (CARGA, DISPARO, ESPERA, ENTREGA).
  - Word-index constants `IDX_X`=0, `IDX_A`=1, `IDX_B`=2, `IDX_C`=3.
  - Default `LARGURA` constant.
- Sub-module `detector_borda`: registers `pronto` into `pronto_q` and outputs the rising-edge pulse; reset to 0 asynchronously by `rst`.

## Test plan
- Load 0x0017, 0x0026, 0x814D, 0x9326, with the core model answering 5 cycles after `inicio` with `Resultado`=0x1234, `overflow`=1 -> X/A/B/C carry those values, `inicio` pulses once 1 cycle after the 4th word, `res_out`=0x1234, `res_overflow`=1, `ops_concluidas`=1.
- Hold `pronto`=1 from the previous operation into a new DISPARO -> no capture until `pronto` falls and rises again.
- Deassert `res_aceito` for 10 cycles in ENTREGA -> `res_valido` and `res_out` stay stable, `dado_pronto`=0, `dado_valido` pulses are ignored.
- With `SEQ_TIMEOUT_EN` and `MAX_ESPERA`=8, the core never answers -> `erro_timeout` pulses 1 cycle, 8 cycles after entering ESPERA, and `dado_pronto`=1 on the next cycle. A `pronto` edge on exactly that cycle -> result captured, no error.
- Assert `rst` after 2 words are loaded -> all outputs return to reset values at once, and the next load starts at X.
- Run 256 back-to-back operations -> `ops_concluidas` wraps from 255 to 0.
